// File: rtl/in_buff.sv
// UART-side front end and single-precision FP core: collects A, B and an opcode byte,
// computes the result (truncating, denormals flushed) and streams it MSB first to the TX.
module in_buff (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       en,
  input  logic       Tx_busy,
  output logic       wr_en,
  output logic [7:0] toTx,
  output logic [7:0] bulbs
);

  typedef enum logic [2:0] {RX, EXEC, DONE, TX_SEND, TX_WAIT} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t      r_state;
  logic [31:0] r_a, r_b;
  logic [7:0]  r_op;
  logic [3:0]  r_idx;
  logic        r_en_d;
  logic        r_op_ready;
  logic [7:0]  r_res [0:3];
  logic [1:0]  r_byte;
  logic [1:0]  r_wait;
  logic        r_div_busy;
  logic [4:0]  r_dcnt;
  logic [24:0] r_rem;
  logic [24:0] r_quo;

  function automatic logic [31:0] f_pack(input logic s, input logic signed [10:0] e,
                                         input logic [22:0] m);
    if (e >= 11'sd255)    return {s, 8'hFF, 23'd0};
    else if (e <= 11'sd0) return {s, 31'd0};
    else                  return {s, e[7:0], m};
  endfunction

  logic        w_sa, w_sb, w_sbe, w_nan_in, w_en_rise;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;

  assign w_sa      = r_a[31];
  assign w_sb      = r_b[31];
  assign w_ea      = r_a[30:23];
  assign w_eb      = r_b[30:23];
  assign w_ma      = (w_ea == 8'd0) ? '0 : {1'b1, r_a[22:0]};
  assign w_mb      = (w_eb == 8'd0) ? '0 : {1'b1, r_b[22:0]};
  assign w_sbe     = w_sb ^ (r_op == 8'h0F);
  assign w_nan_in  = (w_ea == 8'hFF) || (w_eb == 8'hFF);
  assign w_en_rise = en & ~r_en_d;

  // Add/sub: larger magnitude is L; smaller is aligned (truncated) before the add.
  logic        w_swap, w_sL, w_sS;
  logic [7:0]  w_eL, w_eS, w_d;
  logic [23:0] w_mL, w_mS, w_mS_sh, w_diff;
  logic [24:0] w_sum;
  logic [4:0]  w_lz;
  logic [22:0] w_norm;
  logic [31:0] w_addsub;

  assign w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_sL    = w_swap ? w_sbe : w_sa;
  assign w_sS    = w_swap ? w_sa  : w_sbe;
  assign w_eL    = w_swap ? w_eb  : w_ea;
  assign w_eS    = w_swap ? w_ea  : w_eb;
  assign w_mL    = w_swap ? w_mb  : w_ma;
  assign w_mS    = w_swap ? w_ma  : w_mb;
  assign w_d     = w_eL - w_eS;
  assign w_mS_sh = (w_d > 8'd23) ? '0 : (w_mS >> w_d);
  assign w_sum   = {1'b0, w_mL} + {1'b0, w_mS_sh};
  assign w_diff  = w_mL - w_mS_sh;

  always_comb begin
    logic w_found;
    w_found = 1'b0;
    w_lz    = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (!w_found && w_diff[23-i]) begin
        w_lz    = 5'(i);
        w_found = 1'b1;
      end
    end
    w_norm   = 23'(w_diff << w_lz);
    w_addsub = '0;
    if (w_ea == 8'd0 && w_eb == 8'd0)
      w_addsub = '0;
    else if (w_ea == 8'd0)
      w_addsub = {w_sbe, r_b[30:0]};
    else if (w_eb == 8'd0)
      w_addsub = r_a;
    else if (w_sL == w_sS)
      w_addsub = w_sum[24] ? f_pack(w_sL, $signed({3'b0, w_eL}) + 11'sd1, w_sum[23:1])
                           : f_pack(w_sL, $signed({3'b0, w_eL}), w_sum[22:0]);
    else if (w_diff == 24'd0)
      w_addsub = '0;
    else
      w_addsub = f_pack(w_sL, $signed({3'b0, w_eL}) - $signed({6'd0, w_lz}), w_norm);
  end

  logic [24:0]        w_prod;
  logic signed [10:0] w_mexp, w_dexp;
  logic [31:0]        w_mul, w_fast, w_div_sres, w_div_res, w_exec_val;
  logic               w_div_special, w_exec_done, w_ge;
  logic [23:0]        w_rem_sub;

  assign w_prod = 25'((48'(w_ma) * 48'(w_mb)) >> 23);
  assign w_mexp = $signed({3'b0, w_ea}) + $signed({3'b0, w_eb}) - 11'sd127
                + $signed({10'd0, w_prod[24]});
  assign w_mul  = w_prod[24] ? f_pack(w_sa ^ w_sb, w_mexp, w_prod[23:1])
                             : f_pack(w_sa ^ w_sb, w_mexp, w_prod[22:0]);

  always_comb begin
    w_fast = QNAN;
    if (!w_nan_in) begin
      case (r_op)
        8'hF0, 8'h0F: w_fast = w_addsub;
        8'h33:        w_fast = (w_ea == 8'd0 || w_eb == 8'd0) ? {w_sa ^ w_sb, 31'd0} : w_mul;
        default:      w_fast = QNAN;
      endcase
    end
  end

  always_comb begin
    w_div_special = 1'b1;
    w_div_sres    = QNAN;
    if (w_nan_in)
      w_div_sres = QNAN;
    else if (w_eb == 8'd0)
      w_div_sres = (w_ea == 8'd0) ? QNAN : {w_sa ^ w_sb, 8'hFF, 23'd0};
    else if (w_ea == 8'd0)
      w_div_sres = {w_sa ^ w_sb, 31'd0};
    else
      w_div_special = 1'b0;
  end

  // Restoring divider: 25 quotient bits; bit 24 set means mA >= mB (no exponent decrement).
  assign w_ge      = r_rem >= {1'b0, w_mb};
  assign w_rem_sub = w_ge ? (r_rem[23:0] - w_mb) : r_rem[23:0];
  assign w_dexp    = $signed({3'b0, w_ea}) - $signed({3'b0, w_eb}) + 11'sd126
                   + $signed({10'd0, r_quo[24]});
  assign w_div_res = r_quo[24] ? f_pack(w_sa ^ w_sb, w_dexp, r_quo[23:1])
                               : f_pack(w_sa ^ w_sb, w_dexp, r_quo[22:0]);

  assign w_exec_done = (r_op != 8'hCC) || w_div_special || (r_div_busy && r_dcnt == 5'd0);
  assign w_exec_val  = (r_op != 8'hCC) ? w_fast : (w_div_special ? w_div_sres : w_div_res);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RX;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      r_en_d     <= 1'b0;
      r_op_ready <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_res[i] <= '0;
      r_byte     <= '0;
      r_wait     <= '0;
      r_div_busy <= 1'b0;
      r_dcnt     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      wr_en      <= 1'b0;
      toTx       <= '0;
      bulbs      <= '0;
    end else begin
      r_en_d <= en;
      wr_en  <= 1'b0;
      case (r_state)
        RX: if (w_en_rise) begin
          bulbs <= data_in;
          r_idx <= r_idx + 4'd1;
          if (r_idx < 4'd4)      r_a <= {r_a[23:0], data_in};
          else if (r_idx < 4'd8) r_b <= {r_b[23:0], data_in};
          else begin
            r_op    <= data_in;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_exec_done) begin
            r_res[0]   <= w_exec_val[31:24];
            r_res[1]   <= w_exec_val[23:16];
            r_res[2]   <= w_exec_val[15:8];
            r_res[3]   <= w_exec_val[7:0];
            r_op_ready <= 1'b1;
            r_div_busy <= 1'b0;
            r_state    <= DONE;
          end else if (!r_div_busy) begin
            r_rem      <= {1'b0, w_ma};
            r_quo      <= '0;
            r_dcnt     <= 5'd25;
            r_div_busy <= 1'b1;
          end else begin
            r_rem  <= {w_rem_sub, 1'b0};
            r_quo  <= {r_quo[23:0], w_ge};
            r_dcnt <= r_dcnt - 5'd1;
          end
        end
        DONE: begin
          r_byte  <= '0;
          r_state <= TX_SEND;
        end
        TX_SEND: if (!Tx_busy) begin
          toTx    <= r_res[r_byte];
          wr_en   <= 1'b1;
          r_wait  <= 2'd2;
          r_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (r_wait != 2'd0)
            r_wait <= r_wait - 2'd1;
          else if (!Tx_busy) begin
            if (r_byte == 2'd3) begin
              r_op_ready <= 1'b0;
              r_idx      <= '0;
              r_byte     <= '0;
              r_state    <= RX;
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_state <= TX_SEND;
            end
          end
        end
        default: r_state <= RX;
      endcase
    end
  end

endmodule

// File: tb/tb_in_buff.sv
// Directed bench for in_buff: sends 9-byte frames, plays the UART TX busy handshake and
// rebuilds the 32-bit result from the streamed bytes.
module tb_in_buff;

  logic       clk = 1'b0;
  logic       rst, en, Tx_busy;
  logic [7:0] data_in;
  logic       wr_en;
  logic [7:0] toTx, bulbs;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  in_buff dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .en     (en),
    .Tx_busy(Tx_busy),
    .wr_en  (wr_en),
    .toTx   (toTx),
    .bulbs  (bulbs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned hold);
    data_in = b;
    en      = 1'b1;
    repeat (hold) tick();
    en = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                            input int unsigned hold);
    logic [71:0] fr;
    fr = {a, b, op};
    for (int i = 0; i < 9; i++) send_byte(fr[71-8*i -: 8], hold);
  endtask

  task automatic collect(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    int unsigned t;
    got = '0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (wr_en !== 1'b1 && t < 200) begin
        tick();
        t++;
      end
      if (wr_en !== 1'b1) begin
        check({tag, " wr_en timeout"}, 32'(wr_en), 32'd1);
        return;
      end
      got     = {got[23:0], toTx};
      Tx_busy = 1'b1;
      tick();
      check({tag, " wr_en one cycle"}, 32'(wr_en), 32'd0);
      repeat (3) tick();
      Tx_busy = 1'b0;
    end
    check({tag, " result"}, got, exp);
    repeat (4) tick();
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] op, input logic [31:0] exp);
    send_frame(a, b, op, 1);
    collect(tag, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n_wr;
    rst = 1'b0; en = 1'b0; data_in = '0; Tx_busy = 1'b0;
    repeat (3) tick();
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset toTx",  32'(toTx),  32'd0);
    check("reset bulbs", 32'(bulbs), 32'd0);
    rst = 1'b1;
    tick();

    run("div 5/2", 32'h40A00000, 32'h40000000, 8'hCC, 32'h40200000);
    check("bulbs opcode", 32'(bulbs), 32'h000000CC);
    run("add 1+2",     32'h3F800000, 32'h40000000, 8'hF0, 32'h40400000);
    run("sub 1-2",     32'h3F800000, 32'h40000000, 8'h0F, 32'hBF800000);
    run("mul -1*2",    32'hBF800000, 32'h40000000, 8'h33, 32'hC0000000);
    run("div 2/1",     32'h40000000, 32'h3F800000, 8'hCC, 32'h40000000);
    run("div by zero", 32'h3F800000, 32'h00000000, 8'hCC, 32'h7F800000);
    run("bad opcode",  32'h3F800000, 32'h40000000, 8'h55, 32'h7FC00000);
    run("cancel",      32'h3F800000, 32'h3F800000, 8'h0F, 32'h00000000);
    run("inf input",   32'h7F800000, 32'h3F800000, 8'hF0, 32'h7FC00000);
    run("mul ovf",     32'h7F000000, 32'h7F000000, 8'h33, 32'h7F800000);
    run("div 0/0",     32'h00000000, 32'h00000000, 8'hCC, 32'h7FC00000);
    run("mul 1.5^2",   32'h3FC00000, 32'h3FC00000, 8'h33, 32'h40100000);

    // TX held busy: no write strobe may appear until it drops
    Tx_busy = 1'b1;
    send_frame(32'h3F800000, 32'h3F800000, 8'hF0, 1);
    n_wr = 0;
    for (int i = 0; i < 40; i++) begin
      if (wr_en === 1'b1) n_wr++;
      tick();
    end
    check("busy hold wr_en count", n_wr, 32'd0);
    Tx_busy = 1'b0;
    collect("busy hold", 32'h40000000);

    // en held high 3 cycles per byte must capture once per byte
    send_frame(32'h40400000, 32'h40000000, 8'h33, 3);
    check("en hold bulbs", 32'(bulbs), 32'h00000033);
    collect("en hold mul 3*2", 32'h40C00000);

    // abort a partial frame with reset
    send_frame(32'h40A00000, 32'h40000000, 8'hCC, 1);
    collect("pre-reset", 32'h40200000);
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1);
    check("partial bulbs", 32'(bulbs), 32'h00000045);
    rst = 1'b0;
    #2;
    check("mid reset wr_en", 32'(wr_en), 32'd0);
    check("mid reset toTx",  32'(toTx),  32'd0);
    check("mid reset bulbs", 32'(bulbs), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    run("after reset div 3/3", 32'h40400000, 32'h40400000, 8'hCC, 32'h3F800000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/in_buff.md
Name: in_buff

Overview:
- UART-side front end and compute core of the FPGA floating-point unit.
- Collects 9 received bytes: operand A (4 bytes, MSB first), operand B (4 bytes, MSB first), then one opcode byte.
- Performs the selected IEEE-754 single-precision operation and holds the 32-bit result in a 4-byte output register file.
- Streams the result to the UART transmitter, MSB first, using a wr_en / Tx_busy handshake.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  received byte from UART RX.
- en  in  1  byte-valid strobe from UART RX. A byte is captured on the first cycle en is high; a 0→1 edge is detected against a registered copy of en.
- Tx_busy  in  1  UART TX busy; high while a byte is being sent.
- wr_en  out  1  one-cycle write strobe to UART TX.
- toTx  out  8  byte presented to UART TX; valid while wr_en is high.
- bulbs  out  8  LED debug: last captured input byte.

Behaviour:
- Reset (rst=0, async) clears:
  - all operand, opcode and result registers (outputRegFile[0..3]=0);
  - byte counter, op_ready, wr_en, toTx and bulbs;
  - state goes to RX.
- Capture:
  - On a detected en rising edge, data_in is stored at byte index 0..8 and the index increments. bulbs<=data_in.
  - Index 0-3 form A[31:24], A[23:16], A[15:8], A[7:0]; index 4-7 form B in the same order; index 8 is the opcode.
  - en held high for several cycles captures once.
  - en edges outside the RX state are ignored.
- Opcodes:
  - F0 = A+B.
  - 0F = A−B.
  - 33 = A×B.
  - CC = A÷B.
  - Any other value gives result 7FC00000.
- States: RX → EXEC → DONE → TX_SEND → TX_WAIT → (repeat for 4 bytes) → RX.
- EXEC:
  - Add/sub/mul complete in ≤3 cycles.
  - Divide uses a restoring mantissa divider of ≤30 cycles.
  - The result is written to outputRegFile[0]=res[31:24] … [3]=res[7:0].
  - op_ready (internal register) is set high in the same cycle the result registers are written.
- Arithmetic rules:
  - Exponent field 0 is treated as ±0 (denormals flushed).
  - Exponent 255 on any input gives 7FC00000.
  - Mantissas carry the hidden bit; results are normalised; rounding is truncation toward zero.
  - Exponent overflow gives signed infinity (7F800000/FF800000).
  - Exponent underflow gives signed zero.
  - Add/sub of exactly cancelling operands gives +0 (00000000).
  - Multiply or divide with a zero operand gives signed zero.
  - x÷0 with x≠0 gives signed infinity; 0÷0 gives 7FC00000.
  - Result sign is signA XOR signB for mul/div.
- DONE: result held stable for ≥1 cycle after op_ready rises, then go to TX_SEND.
- TX handshake:
  - In TX_SEND, when Tx_busy=0, drive toTx=outputRegFile[k] and pulse wr_en for exactly one cycle (k = 0,1,2,3).
  - TX_WAIT waits 2 cycles, then waits until Tx_busy=0 before the next byte.
  - After byte 3, op_ready clears, the byte index resets to 0, and state returns to RX.
  - outputRegFile keeps the result until the next EXEC.
- Reset mid-operation aborts immediately; a partial frame is discarded.

Test Plan:
- Send 40A00000, 40000000, opcode CC → op_ready rises; outputRegFile = 40200000 (5.0÷2.0=2.5); toTx bytes 40,20,00,00 each with a one-cycle wr_en while Tx_busy=0.
- Send 3F800000, 40000000, F0 → result 40400000. Same operands with 0F → BF800000.
- Send BF800000, 40000000, 33 → C0000000; 40000000, 3F800000, CC → 40000000.
- Send 3F800000, 00000000, CC → 7F800000. Send opcode 55 → 7FC00000.
- Hold Tx_busy=1 during TX → wr_en stays low until Tx_busy=0; en held high 3 cycles → exactly one byte captured; bulbs equals the last byte sent.
- Assert rst=0 after 5 bytes → all outputs 0. Then a full 9-byte frame computes correctly from index 0.
